// File: rtl/pfb_coeff_reload_framer.sv
// Host-side framer for the PFB coefficient reload port: always emits
// exactly NUM_COEFFS words with tlast on the final one.
//
// Ports:
//   clk, sync_reset        clock, asynchronous active-high reset
//   start                  arms a new frame (honoured only when idle)
//   s_axis_coef_*          loosely framed host coefficient stream
//   m_axis_reload_*        strictly framed stream to the memory controller
//   busy                   high whenever the framer is not idle
//   done                   1-cycle pulse after the final output handshake
//   err_short, err_long    sticky framing errors for software
//   coef_count             words written into the FIFO this frame
module pfb_coeff_reload_framer #(
  parameter int NUM_COEFFS = 16384,
  parameter int CNT_W      = 14,
  parameter int COEFF_W    = 25,
  parameter int FIFO_DEPTH = 16
) (
  input  logic             clk,
  input  logic             sync_reset,
  input  logic             start,
  input  logic             s_axis_coef_tvalid,
  input  logic [31:0]      s_axis_coef_tdata,
  input  logic             s_axis_coef_tlast,
  output logic             s_axis_coef_tready,
  output logic             m_axis_reload_tvalid,
  output logic [31:0]      m_axis_reload_tdata,
  output logic             m_axis_reload_tlast,
  input  logic             m_axis_reload_tready,
  output logic             busy,
  output logic             done,
  output logic             err_short,
  output logic             err_long,
  output logic [CNT_W-1:0] coef_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CMAX = (2 ** CNT_W) - 1;
  // A CNT_W-wide counter cannot hold NUM_COEFFS when it is 2**CNT_W,
  // so it pins at its largest value instead of wrapping to zero.
  localparam int SAT_I = (NUM_COEFFS < CMAX) ? NUM_COEFFS : CMAX;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_COEFFS - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(SAT_I);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PAD, S_DRAIN, S_WAIT
  } state_t;

  state_t           r_state;
  logic [32:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_fcnt;
  logic             r_m_valid;
  logic [31:0]      r_m_data;
  logic             r_m_last;
  logic             r_done;
  logic             r_err_short;
  logic             r_err_long;
  logic             r_emitted;
  logic [CNT_W-1:0] r_count;

  logic        w_full;
  logic        w_empty;
  logic        w_s_ready;
  logic        w_acc;
  logic        w_last_idx;
  logic [31:0] w_sext;
  logic        w_wr_en;
  logic [32:0] w_wr_data;
  logic        w_pop_ok;
  logic        w_hs_last;
  logic        w_bypass;
  logic        w_push;
  logic        w_pop;
  logic        w_unused_hi;

  assign w_unused_hi = ^s_axis_coef_tdata[31:COEFF_W];

  assign w_full  = r_fcnt == (AW+1)'(FIFO_DEPTH);
  assign w_empty = r_fcnt == '0;

  assign w_s_ready = ((r_state == S_LOAD) && !w_full)
                   || (r_state == S_DRAIN);
  assign w_acc      = s_axis_coef_tvalid && w_s_ready;
  assign w_last_idx = r_count == LAST_IDX;

  assign w_sext = {{(32-COEFF_W){s_axis_coef_tdata[COEFF_W-1]}},
                   s_axis_coef_tdata[COEFF_W-1:0]};

  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_data = '0;
    unique case (r_state)
      S_LOAD: begin
        w_wr_en   = w_acc;
        w_wr_data = {w_last_idx, w_sext};
      end
      S_PAD: begin
        w_wr_en   = !w_full;
        w_wr_data = {w_last_idx, 32'h0};
      end
      default: ;
    endcase
  end

  // The output register acts as one extra FIFO slot; with the FIFO empty
  // a write goes straight into it for single-cycle latency.
  assign w_pop_ok  = !r_m_valid || m_axis_reload_tready;
  assign w_hs_last = r_m_valid && m_axis_reload_tready && r_m_last;
  assign w_bypass  = w_pop_ok && w_empty && w_wr_en;
  assign w_push    = w_wr_en && !w_bypass;
  assign w_pop     = w_pop_ok && !w_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_wr_data;
  end

  always_ff @(posedge clk or posedge sync_reset) begin
    if (sync_reset) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fcnt      <= '0;
      r_m_valid   <= 1'b0;
      r_m_data    <= '0;
      r_m_last    <= 1'b0;
      r_done      <= 1'b0;
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;
      r_emitted   <= 1'b0;
      r_count     <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_fcnt <= r_fcnt + (AW+1)'(1);
        2'b01:   r_fcnt <= r_fcnt - (AW+1)'(1);
        default: ;
      endcase

      if (w_pop_ok) begin
        if (!w_empty) begin
          {r_m_last, r_m_data} <= r_mem[r_rd_ptr];
          r_m_valid <= 1'b1;
        end else if (w_wr_en) begin
          {r_m_last, r_m_data} <= w_wr_data;
          r_m_valid <= 1'b1;
        end else begin
          r_m_valid <= 1'b0;
        end
      end

      r_done <= w_hs_last;

      if ((r_state == S_IDLE) && start) begin
        r_count   <= '0;
        r_emitted <= 1'b0;
      end else begin
        if (w_wr_en && (r_count != CNT_SAT))
          r_count <= r_count + CNT_W'(1);
        if (w_hs_last) r_emitted <= 1'b1;
      end

      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_err_short <= 1'b0;
            r_err_long  <= 1'b0;
            r_state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_acc) begin
            if (w_last_idx) begin
              if (s_axis_coef_tlast) begin
                r_state <= S_WAIT;
              end else begin
                r_err_long <= 1'b1;
                r_state    <= S_DRAIN;
              end
            end else if (s_axis_coef_tlast) begin
              r_err_short <= 1'b1;
              r_state     <= S_PAD;
            end
          end
        end
        S_PAD: begin
          if (w_wr_en && w_last_idx) r_state <= S_WAIT;
        end
        S_DRAIN: begin
          if (w_acc && s_axis_coef_tlast) r_state <= S_WAIT;
        end
        S_WAIT: begin
          // A slow host in DRAIN can let the final word leave first.
          if (w_hs_last || r_emitted) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s_axis_coef_tready   = w_s_ready;
  assign m_axis_reload_tvalid = r_m_valid;
  assign m_axis_reload_tdata  = r_m_data;
  assign m_axis_reload_tlast  = r_m_last;
  assign busy                 = r_state != S_IDLE;
  assign done                 = r_done;
  assign err_short            = r_err_short;
  assign err_long             = r_err_long;
  assign coef_count           = r_count;

endmodule

// File: tb/tb_pfb_coeff_reload_framer.sv
// Bench for pfb_coeff_reload_framer: random and directed host frames
// checked against a frame-level reference model.
module tb_pfb_coeff_reload_framer;

  localparam int N     = 1024;
  localparam int CW    = 10;
  localparam int DEPTH = 16;
  localparam int CMAX  = (1 << CW) - 1;
  localparam int EXP_CNT = (N < CMAX) ? N : CMAX;

  logic          clk = 1'b0;
  logic          sync_reset;
  logic          start;
  logic          s_valid;
  logic [31:0]   s_data;
  logic          s_last;
  logic          s_ready;
  logic          m_valid;
  logic [31:0]   m_data;
  logic          m_last;
  logic          m_ready;
  logic          busy;
  logic          done;
  logic          err_s;
  logic          err_l;
  logic [CW-1:0] cnt;

  pfb_coeff_reload_framer #(
    .NUM_COEFFS(N), .CNT_W(CW), .COEFF_W(25), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk                  (clk),
    .sync_reset           (sync_reset),
    .start                (start),
    .s_axis_coef_tvalid   (s_valid),
    .s_axis_coef_tdata    (s_data),
    .s_axis_coef_tlast    (s_last),
    .s_axis_coef_tready   (s_ready),
    .m_axis_reload_tvalid (m_valid),
    .m_axis_reload_tdata  (m_data),
    .m_axis_reload_tlast  (m_last),
    .m_axis_reload_tready (m_ready),
    .busy                 (busy),
    .done                 (done),
    .err_short            (err_s),
    .err_long             (err_l),
    .coef_count           (cnt)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int n_done   = 0;
  int rdy_mode = 0;

  logic [32:0] hostq[$];
  logic [32:0] expq[$];
  logic [32:0] gotq[$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sext(input logic [31:0] d);
    int v;
    v = int'(d & 32'h01FF_FFFF);
    if (v >= 16777216) v = v - 33554432;
    return 32'(v);
  endfunction

  // Reference: first min(n,N) host words pass through sign-extended,
  // the rest of the N-word frame is zeros, tlast only on word N-1.
  task automatic build(input int n, input int kind);
    hostq.delete();
    expq.delete();
    for (int i = 0; i < n; i++) begin
      logic [31:0] d;
      d = (kind == 0) ? 32'(i) : $urandom;
      if (kind == 2 && i == 0) d = 32'h0100_0000;
      if (kind == 2 && i == 1) d = 32'hFE00_0ABC;
      hostq.push_back({i == n - 1, d});
    end
    for (int k = 0; k < N; k++)
      expq.push_back({k == N - 1, (k < n) ? sext(hostq[k][31:0]) : 32'h0});
  endtask

  // Output sink: records handshakes, checks hold and done timing,
  // and applies the current ready policy.
  bit          p_stall = 0;
  logic [32:0] p_word = '0;
  bit          p_hs_last = 0;

  always begin
    @(negedge clk);
    if (sync_reset) begin
      p_stall   = 0;
      p_hs_last = 0;
    end else begin
      if (done || p_hs_last) chk("done_pulse", done, p_hs_last);
      if (done) n_done++;
      if (p_stall) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_word", {m_last, m_data}, p_word);
      end
      p_hs_last = m_valid && m_ready && m_last;
      if (m_valid && m_ready) gotq.push_back({m_last, m_data});
      p_stall = m_valid && !m_ready;
      p_word  = {m_last, m_data};
    end
    @(posedge clk);
    #1;
    m_ready = (rdy_mode == 0) ? 1'b1 :
              (rdy_mode == 1) ? 1'($urandom_range(1)) : 1'b0;
  end

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic begin_frame(input string tag, input int n,
                             input int kind, input int mode);
    gotq.delete();
    n_done   = 0;
    rdy_mode = mode;
    build(n, kind);
    pulse_start();
    chk({tag, "_cnt0"}, cnt, 0);
    chk({tag, "_err0"}, {err_s, err_l}, 2'b00);
    chk({tag, "_busy"}, busy, 1);
  endtask

  task automatic drive_host(input int limit, input int gap);
    int i = 0;
    int guard = 0;
    bit acc;
    while (i < hostq.size() && i < limit) begin
      if (gap > 0 && $urandom_range(99) < gap) begin
        s_valid = 1'b0;
      end else begin
        s_valid = 1'b1;
        {s_last, s_data} = hostq[i];
      end
      @(negedge clk);
      acc = s_valid && s_ready;
      @(posedge clk); #1;
      if (acc) begin
        i++;
        n_acc++;
        guard = 0;
      end else begin
        guard++;
      end
      if (guard > 2000) begin
        chk("host_timeout", guard, 0);
        break;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int n);
    int guard = 0;
    while (!(gotq.size() >= N && !busy) && guard < 30000) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "_finish"}, guard < 30000, 1);
    repeat (3) @(negedge clk);
    chk({tag, "_nout"}, gotq.size(), N);
    for (int k = 0; k < N && k < gotq.size(); k++) begin
      chk({tag, "_word"}, {32'(k), 31'h0, gotq[k]},
          {32'(k), 31'h0, expq[k]});
      if (gotq[k] !== expq[k]) break;
    end
    chk({tag, "_err_short"}, err_s, n < N);
    chk({tag, "_err_long"}, err_l, n > N);
    chk({tag, "_count"}, cnt, EXP_CNT);
    chk({tag, "_ndone"}, n_done, 1);
    chk({tag, "_idle"}, {busy, m_valid, s_ready}, 3'b000);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tvalid"}, m_valid, 0);
    chk({tag, "_tdata"}, m_data, 0);
    chk({tag, "_tlast"}, m_last, 0);
    chk({tag, "_flags"}, {busy, done, err_s, err_l, s_ready}, 5'b0);
    chk({tag, "_count"}, cnt, 0);
  endtask

  initial begin
    int a0;
    int lens[3];
    sync_reset = 1'b1;
    start      = 1'b0;
    s_valid    = 1'b0;
    s_data     = '0;
    s_last     = 1'b0;
    m_ready    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    sync_reset = 1'b0;

    // Full-length counting frame, with single-cycle latency check.
    begin_frame("full", N, 0, 0);
    a0 = n_acc;
    fork
      drive_host(N, 0);
      begin
        int g = 0;
        do begin
          @(negedge clk);
          g++;
        end while (!(s_valid && s_ready) && g < 100);
        chk("lat_pre", m_valid, 0);
        @(negedge clk);
        chk("lat_1cyc", m_valid, 1);
      end
    join
    chk("full_acc", n_acc - a0, N);
    check_frame("full", N);

    // Short frame; a start pulse while padding must be ignored.
    begin_frame("short", 100, 0, 0);
    drive_host(100, 0);
    pulse_start();
    check_frame("short", 100);

    // Long frame: surplus words are swallowed.
    begin_frame("long", N + 6, 0, 0);
    a0 = n_acc;
    drive_host(N + 6, 0);
    chk("long_acc", n_acc - a0, N + 6);
    check_frame("long", N + 6);

    // Random backpressure with a long stall that fills the FIFO.
    begin_frame("stall", N, 1, 1);
    fork
      drive_host(N, 0);
      begin
        int a1;
        repeat (100) @(posedge clk);
        rdy_mode = 2;
        a1 = n_acc;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("stall_s_ready", s_ready, 0);
        chk("stall_fill", (n_acc - a1) <= DEPTH + 1, 1);
        chk("stall_m_valid", m_valid, 1);
        rdy_mode = 1;
      end
    join
    check_frame("stall", N);

    // Sign extension on both polarities, random host gaps.
    begin_frame("sext", N, 2, 1);
    drive_host(N, 30);
    check_frame("sext", N);
    chk("sext_neg", gotq[0][31:0], 32'hFF00_0000);
    chk("sext_pos", gotq[1][31:0], 32'h0000_0ABC);

    // Length boundaries around NUM_COEFFS.
    lens[0] = 1;
    lens[1] = N - 1;
    lens[2] = N + 1;
    for (int b = 0; b < 3; b++) begin
      begin_frame("bound", lens[b], 1, 1);
      drive_host(lens[b], 20);
      check_frame("bound", lens[b]);
    end

    // Reset mid-frame, then a clean frame from index 0.
    begin_frame("abort", N, 0, 0);
    drive_host(500, 0);
    chk("abort_cnt_mid", cnt, 500);
    sync_reset = 1'b1;
    #1;
    chk_all_zero("abort_rst");
    gotq.delete();
    repeat (2) @(posedge clk);
    #1;
    sync_reset = 1'b0;
    begin_frame("after", N, 0, 0);
    drive_host(N, 0);
    check_frame("after", N);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
